// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the round-robin ALU scheduler.
package alu_sched_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned OP_W   = 3;

   typedef enum logic [2:0] {
      ADD  = 3'b000,
      SUB  = 3'b001,
      AND  = 3'b010,
      OR   = 3'b011,
      XOR  = 3'b100,
      ADD2 = 3'b101,
      XOR2 = 3'b110,
      SHR  = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   // Operation captured from the granted requester
   typedef struct packed {
      op_e               op;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } alu_req_t;

endpackage

// File: rtl/alu_sched_alu_core.sv
// Combinational 8-bit ALU shared by all requesters; result wraps modulo 256.
module alu_core
   import alu_sched_pkg::*;
(
   input  op_e               op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] result_c_o,
   output logic              zero_c_o
);

   always_comb begin
      result_c_o = '0;
      case (op_i)
         ADD, ADD2: result_c_o = a_i + b_i;
         SUB:       result_c_o = a_i - b_i;
         AND:       result_c_o = a_i & b_i;
         OR:        result_c_o = a_i | b_i;
         XOR, XOR2: result_c_o = a_i ^ b_i;
         SHR:       result_c_o = a_i >> 1;
         default:   result_c_o = '0;
      endcase
   end

   assign zero_c_o = (result_c_o == '0);

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one registered ALU stage between NUM_REQ requesters.
// Optional ALU_SCHED_STATS_EN adds a saturating 16-bit completed-operation counter (op_count).
module alu_sched #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_W  = alu_sched_pkg::DATA_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*DATA_W-1:0]    req_a,
   input  logic [NUM_REQ*DATA_W-1:0]    req_b,
   input  logic [NUM_REQ*3-1:0]         req_op,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
   output logic [DATA_W-1:0]            rsp_result,
   output logic                         rsp_zero
`ifdef ALU_SCHED_STATS_EN
   ,
   output logic [15:0]                  op_count
`endif
);

   import alu_sched_pkg::*;

   localparam int unsigned ID_W = $clog2(NUM_REQ);

   state_e            state_q, state_d;
   alu_req_t          op_q;
   logic [ID_W-1:0]   gnt_c, gnt_q, rr_ptr_q, idx_c;
   logic              gnt_found_c, hs_c;
   logic [DATA_W-1:0] alu_result_c;
   logic              alu_zero_c;
   logic              rsp_valid_q, rsp_zero_q;
   logic [ID_W-1:0]   rsp_id_q;
   logic [DATA_W-1:0] rsp_result_q;

   // First valid requester at or after rr_ptr, wrapping around
   always_comb begin
      gnt_found_c = 1'b0;
      gnt_c       = '0;
      idx_c       = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx_c = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
         if (!gnt_found_c && req_valid[idx_c]) begin
            gnt_found_c = 1'b1;
            gnt_c       = idx_c;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Grant is only offered from IDLE and never while reset is applied
   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      hs_c      = 1'b0;
      case (state_q)
         IDLE: begin
            if (gnt_found_c && !rst) begin
               req_ready[gnt_c] = 1'b1;
               hs_c             = 1'b1;
               state_d          = EXEC;
            end
         end
         EXEC:    state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q         <= '0;
         gnt_q        <= '0;
         rr_ptr_q     <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
      end else begin
         if (hs_c) begin
            op_q.op <= op_e'(req_op[32'(gnt_c)*OP_W +: OP_W]);
            op_q.a  <= req_a[32'(gnt_c)*DATA_W +: DATA_W];
            op_q.b  <= req_b[32'(gnt_c)*DATA_W +: DATA_W];
            gnt_q   <= gnt_c;
         end
         if (state_q == EXEC) begin
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= gnt_q;
            rsp_result_q <= alu_result_c;
            rsp_zero_q   <= alu_zero_c;
         end
         if (state_q == RESP && rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rr_ptr_q    <= ID_W'((32'(gnt_q) + 1) % NUM_REQ);
         end
      end
   end

   alu_core u_alu_core (
      .op_i       (op_q.op),
      .a_i        (op_q.a),
      .b_i        (op_q.b),
      .result_c_o (alu_result_c),
      .zero_c_o   (alu_zero_c)
   );

   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_zero   = rsp_zero_q;

`ifdef ALU_SCHED_STATS_EN
   logic [15:0] op_count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                                 op_count_q <= '0;
      else if (rsp_valid_q && rsp_ready && op_count_q != 16'hFFFF) op_count_q <= op_count_q + 16'd1;
   end

   assign op_count = op_count_q;
`endif

endmodule

// File: doc/alu_sched.md
# alu_sched

Round-robin scheduler that shares one 8-bit ALU between NUM_REQ requesters. Each requester presents an operation (op code plus two operands) over a valid/ready handshake. The scheduler grants one requester at a time and executes the operation in a registered ALU stage. It returns the result, the zero flag and the requester ID over a response handshake. It sits between the datapath clients and the single shared ALU instance.

## Interface
- NUM_REQ, default 4: number of requesters, range 2..8.
- DATA_W, default 8: operand and result width; only 8 is supported.
- clk, input, 1: clock; all state updates on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- req_valid, input, NUM_REQ: per-requester request valid.
- req_ready, output, NUM_REQ: one-hot grant/accept; the request is accepted when req_valid[i] and req_ready[i] are both high.
- req_a, input, NUM_REQ*8: operand A; requester i occupies bits [8i+7:8i].
- req_b, input, NUM_REQ*8: operand B, packed the same way.
- req_op, input, NUM_REQ*3: op code; requester i occupies bits [3i+2:3i].
- rsp_valid, output, 1: response valid.
- rsp_ready, input, 1: response consumer ready.
- rsp_id, output, clog2(NUM_REQ): index of the requester that owns the response.
- rsp_result, output, 8: ALU result.
- rsp_zero, output, 1: high when rsp_result == 0.

## Operation
- **States:**
  - IDLE: waiting for a request.
  - EXEC: operands latched, ALU evaluated, result registered.
  - RESP: rsp_valid held until the consumer takes it.
- **IDLE behaviour:**
  - Grant g is the first requester with req_valid high, searching from rr_ptr upward with wrap-around.
  - req_ready[g] is driven combinationally high. All other req_ready bits are 0.
  - On handshake, latch op, A, B and g, then go to EXEC.
  - With no valid request, stay in IDLE and keep req_ready = 0.
- **EXEC behaviour:**
  - Register the ALU output into rsp_result and rsp_zero.
  - Set rsp_id = g and rsp_valid = 1, then go to RESP.
- **RESP behaviour:**
  - If rsp_ready is high: clear rsp_valid, set rr_ptr = (g+1) mod NUM_REQ, go to IDLE.
  - If rsp_ready is low: hold all rsp_* outputs stable.
- **Op codes:**

  | Code | Operation |
  |---|---|
  | 000 | A+B |
  | 001 | A−B |
  | 010 | A&B |
  | 011 | A\|B |
  | 100 | A^B |
  | 101 | A+B |
  | 110 | A^B |
  | 111 | A>>1 (logical, MSB filled with 0) |

- **Arithmetic width:** 8-bit modulo; carry and borrow are discarded. 0xFF+0x01 gives 0x00 with zero=1.
- **Requester rules:**
  - A requester holds req_valid, operands and op stable until it sees req_ready.
  - A requester must not drop req_valid before its handshake.
- **req_ready outside IDLE:** all bits are 0 in EXEC, in RESP, and while rst is high.

## Timing
- **Reset values:**
  - State = IDLE, rr_ptr = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_result = 0x00, rsp_zero = 0.
  - req_ready = 0.
- **Latency:** handshake in cycle N gives rsp_valid high in cycle N+2.
- **Throughput:** at most one operation per 3 cycles when rsp_ready is held high.
- **Fairness:** a requester holding valid is granted within NUM_REQ operations.
- **Simultaneous requests:** resolved in a single cycle by rr_ptr order.
- **Request arriving during EXEC/RESP:** waits; it is considered in the next IDLE cycle.
- **Reset mid-operation:** an in-flight operation is discarded with no response, and rr_ptr returns to 0.

## Configuration
- **ALU_SCHED_STATS_EN defined:**
  - Adds output op_count, 16 bits, reset 0.
  - Increments on every response handshake (rsp_valid & rsp_ready).
  - Saturates at 0xFFFF.
- **ALU_SCHED_STATS_EN undefined:** the port and counter are absent. All other behaviour is identical.

## Structure
- **Package alu_sched_pkg:**
  - Op-code enum (ADD, SUB, AND, OR, XOR, ADD2, XOR2, SHR).
  - State enum (IDLE, EXEC, RESP).
  - DATA_W constant.
- **Sub-module alu_core:**
  - Purely combinational 8-bit ALU implementing the op table.
  - Produces result and zero.
  - One instance, fed from the latched operands.

## Test plan
- Reset release, req0 valid with op=000, A=0x05, B=0x03: req_ready[0] high on the first cycle. Two cycles later rsp_valid=1, rsp_id=0, rsp_result=0x08, rsp_zero=0.
- req0 with op=001, A=0x10, B=0x10: rsp_result=0x00, rsp_zero=1. Then op=000, A=0xFF, B=0x01: rsp_result=0x00, rsp_zero=1. Then op=111, A=0x81: rsp_result=0x40.
- All 4 requesters valid continuously: grants in order 0,1,2,3,0; rsp_id follows the same order.
- rsp_ready held low 5 cycles with result 0x3C pending: rsp_* stable throughout, no req_ready asserted, next grant only after the response handshake.
- rst asserted during EXEC of req2's operation: no response emitted. After release, rsp_valid=0, and with req2 and req0 valid, req0 is granted first.
- With ALU_SCHED_STATS_EN defined: 3 completed operations give op_count=3. Forced count 0xFFFF plus 1 operation stays at 0xFFFF.
